// File: rtl/pair_scan_pkg.sv
// Shared types, defaults and helpers for the pair scan controller.
package pair_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } scan_state_e;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_SLOT_CYCLES = 27;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after grant_ptr.
module rr_arbiter
  import pair_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  localparam int unsigned IDX_W = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  grant_ptr,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  int unsigned      pos;
  logic [IDX_W-1:0] idx;

  // Walk the channels starting at grant_ptr, wrapping once, and take the first request.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pos = 32'(grant_ptr) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      idx = IDX_W'(pos);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/pair_scan_ctrl.sv
// Round-robin pair-break scanner over NUM_CH serial streams with a valid/ready event report.
// All state updates on the falling edge of sys_clk.
module pair_scan_ctrl
  import pair_scan_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES,
  localparam int unsigned IDX_W      = clog2(NUM_CH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] stream,
  output logic [NUM_CH-1:0] pair_out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_ch,
  output logic [CNT_W-1:0]  evt_count,
  output logic              busy
);

  localparam int unsigned TMR_W = clog2(SLOT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  scan_state_e       state_q, state_d;
  logic [TMR_W-1:0]  timer_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] pair_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [IDX_W-1:0]  grant_ptr_q;
  logic              evt_valid_q;
  logic [IDX_W-1:0]  evt_ch_q;
  logic [CNT_W-1:0]  evt_count_q;

  logic              tick;
  logic              ptr_last;
  logic [IDX_W-1:0]  ptr_nxt;
  logic              mis;
  logic              hit;
  logic              hs;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;

  // en=0 freezes the scan immediately, so a slot ending in that cycle is not visited.
  assign tick     = en && (state_q != ST_IDLE) && (timer_q == TMR_LAST);
  assign ptr_last = (ptr_q == CH_LAST);
  assign ptr_nxt  = ptr_last ? '0 : ptr_q + 1'b1;
  assign mis      = stream[ptr_q] ^ prev_q[ptr_q];
  assign hit      = tick && (state_q == ST_RUN) && mis && !clr;
  assign hs       = evt_valid_q && evt_ready;

  assign pair_out  = pair_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_count = evt_count_q;
  assign busy      = (state_q != ST_IDLE);

  // FSM state register.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: clr, then en=0, then the normal prime-then-run sequence.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = en ? ST_PRIME : ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (tick && ptr_last) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Slot timer, scan pointer, stored previous bits and per-channel visit result.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_q <= '0;
      ptr_q   <= '0;
      prev_q  <= '0;
      pair_q  <= '0;
    end else if (clr) begin
      timer_q <= '0;
      ptr_q   <= '0;
      pair_q  <= '0;
    end else if (!en || (state_q == ST_IDLE)) begin
      timer_q <= '0;
      ptr_q   <= '0;
    end else begin
      timer_q <= tick ? '0 : timer_q + 1'b1;
      if (tick) begin
        prev_q[ptr_q] <= stream[ptr_q];
        ptr_q         <= ptr_nxt;
        if (state_q == ST_RUN) pair_q[ptr_q] <= mis;
      end
    end
  end

  // Pending/count next state: a new mismatch beats the handshake clear; clr beats everything.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (hs) pend_d[evt_ch_q] = 1'b0;
    if (hit) begin
      pend_d[ptr_q] = 1'b1;
      if (cnt_q[ptr_q] != CNT_MAX) cnt_d[ptr_q] = cnt_q[ptr_q] + 1'b1;
    end
    if (clr) begin
      pend_d = '0;
      cnt_d  = '{default: '0};
    end
  end

  // Pending flags and saturating event counters.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (pend_q),
    .grant_ptr (grant_ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  // Report register: snapshot on grant, hold until accepted, then advance the grant pointer.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_count_q <= '0;
      grant_ptr_q <= '0;
    end else if (clr) begin
      evt_valid_q <= 1'b0;
    end else if (hs) begin
      evt_valid_q <= 1'b0;
      grant_ptr_q <= (evt_ch_q == CH_LAST) ? '0 : evt_ch_q + 1'b1;
    end else if (!evt_valid_q && gnt_vld) begin
      evt_valid_q <= 1'b1;
      evt_ch_q    <= gnt_idx;
      evt_count_q <= cnt_q[gnt_idx];
    end
  end

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Directed bench for pair_scan_ctrl with NUM_CH=4, CNT_W=4, SLOT_CYCLES=2.
// Inputs change and outputs are sampled 1 time unit after the rising edge; the DUT updates on
// the falling edge, so each step() spans exactly one DUT update.
module tb_pair_scan_ctrl;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SLOT_CYCLES = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en        = 1'b0;
  logic       clr       = 1'b0;
  logic       evt_ready = 1'b0;
  logic [3:0] stream    = 4'b0000;
  logic [3:0] pair_out;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic [3:0] evt_count;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  pair_scan_ctrl #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .clr       (clr),
    .stream    (stream),
    .pair_out  (pair_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_count (evt_count),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check_rep(input string tag, input logic v, input logic [1:0] ch,
                           input logic [3:0] cnt);
    check_eq({tag, "_valid"}, evt_valid, v);
    check_eq({tag, "_ch"}, evt_ch, ch);
    check_eq({tag, "_count"}, evt_count, cnt);
  endtask

  // Steps n cycles and requires evt_valid to stay low throughout.
  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      step(1);
      if (evt_valid !== 1'b0) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  // Reset, enable with stream=0 and run through PRIME: returns in RUN, ptr=0, timer=0.
  // From here, channel c is visited at relative step 2 + 2c + 8p.
  task automatic restart();
    sys_rst_n = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    evt_ready = 1'b0;
    stream    = 4'b0000;
    step(2);
    sys_rst_n = 1'b1;
    en        = 1'b1;
    step(9);
  endtask

  initial begin
    int qv;
    int bb;

    // Power-on reset
    step(3);
    check_eq("rst_pair", pair_out, 4'b0000);
    check_rep("rst", 1'b0, 2'd0, 4'd0);
    check_eq("rst_busy", busy, 1'b0);

    // Reset mid-RUN with pending=0101 and a held report
    restart();
    stream = 4'b0101;
    step(6);
    check_eq("pre_rst_pair", pair_out, 4'b0101);
    check_rep("pre_rst", 1'b1, 2'd0, 4'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("arst_pair", pair_out, 4'b0000);
    check_rep("arst", 1'b0, 2'd0, 4'd0);
    check_eq("arst_busy", busy, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    stream    = 4'b0000;

    // PRIME: 4 ticks, 8 cycles, busy and no events
    qv = 0;
    bb = 0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      if (evt_valid !== 1'b0) qv++;
      if (k <= 8 && busy !== 1'b1) bb++;
    end
    check_eq("prime_quiet", qv, 0);
    check_eq("prime_busy", bb, 0);

    // Single mismatch on channel 2
    stream = 4'b0100;
    step(5);
    check_eq("ch2_pair_before", pair_out, 4'b0000);
    step(1);
    check_eq("ch2_pair_visit", pair_out, 4'b0100);
    check_eq("ch2_latency", evt_valid, 1'b0);
    step(1);
    check_rep("ch2_rep", 1'b1, 2'd2, 4'd1);
    step(6);
    check_rep("ch2_hold", 1'b1, 2'd2, 4'd1);
    step(1);
    check_eq("ch2_pair_next", pair_out, 4'b0000);
    evt_ready = 1'b1;
    step(1);
    check_eq("ch2_ack", evt_valid, 1'b0);
    expect_quiet("ch2_only_one", 6);
    evt_ready = 1'b0;

    // All four toggle, stall 10 cycles, then drain in order 0..3
    restart();
    stream = 4'b1111;
    step(3);
    check_rep("rr_first", 1'b1, 2'd0, 4'd1);
    step(9);
    check_rep("rr_stall", 1'b1, 2'd0, 4'd1);
    evt_ready = 1'b1;
    step(1);
    check_eq("rr_gap0", evt_valid, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step(1);
      check_rep($sformatf("rr_rep%0d", k), 1'b1, 2'(k), 4'd1);
      step(1);
      check_eq($sformatf("rr_gap%0d", k), evt_valid, 1'b0);
    end
    expect_quiet("rr_drained", 10);

    // Channel 1 toggles on every visit: count saturates at 15
    restart();
    evt_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      stream[1] = ~stream[1];
      step(5);
      check_rep($sformatf("sat%0d", p), 1'b1, 2'd1, (p + 1 > 15) ? 4'd15 : 4'(p + 1));
      step(3);
    end

    // Handshake on ch3 in the same cycle ch3 mismatches again: set wins
    restart();
    stream = 4'b1000;
    step(9);
    check_rep("same_first", 1'b1, 2'd3, 4'd1);
    stream = 4'b0000;
    step(6);
    check_rep("same_hold", 1'b1, 2'd3, 4'd1);
    evt_ready = 1'b1;
    step(1);
    check_eq("same_ack", evt_valid, 1'b0);
    check_eq("same_pair", pair_out, 4'b1000);
    step(1);
    check_rep("same_second", 1'b1, 2'd3, 4'd2);
    step(1);
    check_eq("same_ack2", evt_valid, 1'b0);
    expect_quiet("same_quiet", 5);

    // clr during a held report, then en=0 for one cycle
    restart();
    stream = 4'b0001;
    step(3);
    check_rep("clr_pre", 1'b1, 2'd0, 4'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check_eq("clr_valid", evt_valid, 1'b0);
    check_eq("clr_pair", pair_out, 4'b0000);
    check_eq("clr_busy", busy, 1'b1);
    expect_quiet("clr_prime_quiet", 8);
    stream = 4'b0000;
    step(2);
    check_eq("clr_run_pair", pair_out, 4'b0001);
    step(1);
    check_rep("clr_count_zeroed", 1'b1, 2'd0, 4'd1);
    en = 1'b0;
    step(1);
    check_eq("en0_busy", busy, 1'b0);
    check_eq("en0_drain_valid", evt_valid, 1'b1);
    check_eq("en0_pair_kept", pair_out, 4'b0001);
    en        = 1'b1;
    evt_ready = 1'b1;
    step(1);
    check_eq("reen_busy", busy, 1'b1);
    check_eq("reen_ack", evt_valid, 1'b0);
    expect_quiet("reen_prime_quiet", 8);
    check_eq("reen_pair_kept", pair_out, 4'b0001);
    stream = 4'b0001;
    step(2);
    check_eq("reen_pair", pair_out, 4'b0001);
    step(1);
    check_rep("reen_count_kept", 1'b1, 2'd0, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
